cordic_cos_pipeline: RTL and testbench
======================================

Name: cordic_cos_pipeline

Overview:
- Fully pipelined CORDIC in rotation mode. Computes cos(target) for a fixed-point angle, one new sample per enabled clock.
- A parallel pipeline carries target squared alongside, so both outputs appear on the same cycle.
- Used by the final-adder stage. That stage feeds two samples back-to-back, then watches valid and pipeline_cleared.

Parameters:
- CORDIC_DATA_WIDTH, 22: width of target/result. Signed fixed point, Q2.20 (2 integer bits incl. sign, 20 fractional).
- FLOAT_DATA_WIDTH, 32: width of the squared output.
- ITERATIONS, 16: number of CORDIC rotation stages, 1..20.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- clk_en  in  1  global enable; 0 freezes every register in the block.
- target  in  22  signed Q2.20 angle in radians. Supported range |target| <= 1.0 (0x100000).
- start  in  1  sample target this cycle (qualified by clk_en).
- result  out  22  signed Q2.20 cos(target).
- squared  out  32  unsigned Q12.20 target², aligned with result.
- valid  out  1  result/squared hold a started sample.
- pipeline_cleared  out  1  no started sample is in flight.

Behaviour:
Reset (rst=0, asynchronous):
- All stage registers, per-stage valid bits, result, squared and valid go to 0.
- pipeline_cleared = 1.
- Samples in flight are discarded. Deassertion takes effect at the next rising edge.

Enable:
- All updates occur only on edges where clk_en=1.
- With clk_en=0, everything holds, including outputs; start is ignored.

Stage 0 (input register), on an enabled edge:
- x0 = K = 636751 (0.607252935·2^20).
- y0 = 0.
- z0 = target.
- v0 = start.
- sq0 = (target·target) >>> 20, computed at full 44-bit precision, truncated, zero-extended to 32 bits.

Stage i = 0..ITERATIONS-1 (one register each):
- If z >= 0: x' = x − (y>>>i), y' = y + (x>>>i), z' = z − ATAN[i].
- Else: x' = x + (y>>>i), y' = y − (x>>>i), z' = z + ATAN[i].
- >>> is arithmetic shift.
- ATAN[i] = round(atan(2^-i)·2^20). ATAN[0] = 823550, ATAN[1] = 486170, ATAN[2] = 256879, and so on.
- Internal x/y/z use 24 bits (2 guard bits), so intermediate values cannot wrap.
- The valid bit and sq travel unchanged with the data.

Output register:
- result = final x saturated to 22 bits. squared = sq. valid = final valid bit.

Latency:
- A sample accepted at enabled edge E appears on result/squared/valid after enabled edge E + ITERATIONS + 1.
- valid is high for exactly one enabled cycle per started sample.
- Back-to-back starts produce back-to-back valids, in order.

Non-started samples:
- Cycles with start=0 still propagate data; their outputs are don't-care with valid=0.
- Outputs are always driven (no X after reset).

pipeline_cleared:
- Registered.
- 1 when no valid bit is set in stage 0, any rotation stage, or the output register. Otherwise 0.
- Drops to 0 on the edge accepting a start.
- Returns to 1 on the edge after valid's last high cycle.

Edge cases:
- |target| > 1.0 up to 1.74: accuracy not guaranteed; must not overflow internally.
- target = 0: result = 2^20 within tolerance.
- Simultaneous start with outputs emerging: independent, no interaction.

Accuracy:
- |result − round(cos(target)·2^20)| <= 32 LSB for ITERATIONS = 16.
- squared is exact per the formula above.

Test Plan:
- Reset: rst=0 mid-stream with 3 samples in flight → result=0, squared=0, valid=0, pipeline_cleared=1 immediately. No valid ever emerges for those samples.
- Single sample: target=0x000000, start for 1 cycle → exactly 17 edges later valid=1 for 1 cycle, result=1048576±32, squared=0. pipeline_cleared is 0 from the accept edge until the edge after valid.
- Known angles: target=0x100000 (1.0) → result=566551±32, squared=0x00100000. target=0x3F0000 (−0.0625·... i.e. −65536/2^20 = −0.0625) → result=1046530±32, squared=0x00001000.
- Symmetry and back-to-back: targets +0x080000 and −0x080000 on consecutive cycles → two consecutive valids. Both result=920218±32 (cos 0.5). Both squared=0x00040000.
- clk_en stall: accept sample, then hold clk_en=0 for 5 cycles mid-flight → outputs frozen. valid appears after 17 enabled edges (22 total). start asserted while clk_en=0 is ignored.
- Throughput: 32 consecutive random targets in [−1,1] → 32 consecutive valids, in order, each within tolerance against a cos/square model.

Source files
------------

// File: rtl/cordic_cos_pipeline.sv
// Fully pipelined rotation-mode CORDIC producing cos(target) in Q2.20,
// with target squared carried alongside so both leave on the same cycle.
module cordic_cos_pipeline #(
  parameter int unsigned CORDIC_DATA_WIDTH = 22,
  parameter int unsigned FLOAT_DATA_WIDTH  = 32,
  parameter int unsigned ITERATIONS        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic [CORDIC_DATA_WIDTH-1:0] target,
  input  logic                         start,
  output logic [CORDIC_DATA_WIDTH-1:0] result,
  output logic [FLOAT_DATA_WIDTH-1:0]  squared,
  output logic                         valid,
  output logic                         pipeline_cleared
);

  localparam int unsigned GUARD = 2;
  localparam int unsigned IW    = CORDIC_DATA_WIDTH + GUARD;
  localparam int unsigned PW    = 2 * CORDIC_DATA_WIDTH;
  localparam int unsigned FRAC  = 20;

  localparam logic signed [IW-1:0] K_INIT  = IW'(636751);
  localparam logic signed [IW-1:0] SAT_MAX = IW'((64'd1 << (CORDIC_DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

  // round(atan(2^-i) * 2^20)
  function automatic logic signed [IW-1:0] atan_lut(input int unsigned idx);
    case (idx)
      0:       atan_lut = IW'(823550);
      1:       atan_lut = IW'(486170);
      2:       atan_lut = IW'(256879);
      3:       atan_lut = IW'(130396);
      4:       atan_lut = IW'(65451);
      5:       atan_lut = IW'(32757);
      6:       atan_lut = IW'(16383);
      7:       atan_lut = IW'(8192);
      8:       atan_lut = IW'(4096);
      9:       atan_lut = IW'(2048);
      10:      atan_lut = IW'(1024);
      11:      atan_lut = IW'(512);
      12:      atan_lut = IW'(256);
      13:      atan_lut = IW'(128);
      14:      atan_lut = IW'(64);
      15:      atan_lut = IW'(32);
      16:      atan_lut = IW'(16);
      17:      atan_lut = IW'(8);
      18:      atan_lut = IW'(4);
      19:      atan_lut = IW'(2);
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic logic [CORDIC_DATA_WIDTH-1:0] saturate(input logic signed [IW-1:0] x);
    if (x > SAT_MAX)      saturate = SAT_MAX[CORDIC_DATA_WIDTH-1:0];
    else if (x < SAT_MIN) saturate = SAT_MIN[CORDIC_DATA_WIDTH-1:0];
    else                  saturate = x[CORDIC_DATA_WIDTH-1:0];
  endfunction

  logic signed [IW-1:0]         x_q  [ITERATIONS+1];
  logic signed [IW-1:0]         y_q  [ITERATIONS+1];
  logic signed [IW-1:0]         z_q  [ITERATIONS+1];
  logic [FLOAT_DATA_WIDTH-1:0]  sq_q [ITERATIONS+1];
  logic [ITERATIONS:0]          v_q;

  logic signed [PW-1:0]         target_ext;
  logic signed [PW-1:0]         prod;
  logic [FLOAT_DATA_WIDTH-1:0]  sq_next;
  logic signed [IW-1:0]         z_init;

  // Full-precision square, then drop the fractional half of the product
  always_comb begin
    target_ext = {{CORDIC_DATA_WIDTH{target[CORDIC_DATA_WIDTH-1]}}, target};
    prod       = target_ext * target_ext;
    sq_next    = FLOAT_DATA_WIDTH'(prod >>> FRAC);
    z_init     = {{GUARD{target[CORDIC_DATA_WIDTH-1]}}, target};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= int'(ITERATIONS); i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        z_q[i]  <= '0;
        sq_q[i] <= '0;
      end
      v_q              <= '0;
      result           <= '0;
      squared          <= '0;
      valid            <= 1'b0;
      pipeline_cleared <= 1'b1;
    end else if (clk_en) begin
      x_q[0]  <= K_INIT;
      y_q[0]  <= '0;
      z_q[0]  <= z_init;
      sq_q[0] <= sq_next;
      v_q     <= {v_q[ITERATIONS-1:0], start};

      // Rotate toward z = 0; the sign of the residual angle picks the direction
      for (int i = 0; i < int'(ITERATIONS); i++) begin
        if (!z_q[i][IW-1]) begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] - atan_lut(i);
        end else begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] + atan_lut(i);
        end
        sq_q[i+1] <= sq_q[i];
      end

      result           <= saturate(x_q[ITERATIONS]);
      squared          <= sq_q[ITERATIONS];
      valid            <= v_q[ITERATIONS];
      // Reflects the valid bits as they will be after this edge
      pipeline_cleared <= ~(start | (|v_q));
    end
  end

endmodule

// File: tb/tb_cordic_cos_pipeline.sv
// Randomized bench for cordic_cos_pipeline against a real-arithmetic cos/square model.
module tb_cordic_cos_pipeline;

  localparam int unsigned LAT = 17;
  localparam longint      TOL = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [21:0] target;
  logic [21:0] result;
  logic [31:0] squared;
  logic        valid;
  logic        pipeline_cleared;

  cordic_cos_pipeline dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .target           (target),
    .start            (start),
    .result           (result),
    .squared          (squared),
    .valid            (valid),
    .pipeline_cleared (pipeline_cleared)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned ecount   = 0;
  int unsigned acc_edge[$];
  logic [21:0] acc_tgt[$];

  task automatic check_eq(input string tag, input longint obs, input longint exp,
                          input longint tol = 0);
    longint diff;
    checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at enabled edge %0d",
               tag, obs, exp, tol, ecount);
    end
  endtask

  function automatic longint cos_ref(input logic [21:0] t);
    real a;
    a = real'(longint'($signed(t))) / 1048576.0;
    return longint'($cos(a) * 1048576.0);
  endfunction

  function automatic longint sq_ref(input logic [21:0] t);
    longint v;
    v = longint'($signed(t));
    return (v * v) >>> 20;
  endfunction

  function automatic logic [21:0] rand_angle();
    int r;
    r = int'($urandom_range(0, 2097152)) - 1048576;
    return 22'(r);
  endfunction

  // A sample accepted at enabled edge E is in flight for edges E..E+LAT and shows at E+LAT
  task automatic check_outputs();
    bit exp_valid;
    while (acc_edge.size() > 0 && acc_edge[0] + LAT < ecount) begin
      void'(acc_edge.pop_front());
      void'(acc_tgt.pop_front());
    end
    exp_valid = (acc_edge.size() > 0) && (acc_edge[0] + LAT == ecount);
    check_eq("valid", longint'(valid), longint'(exp_valid));
    check_eq("pipeline_cleared", longint'(pipeline_cleared), longint'(acc_edge.size() == 0));
    if (exp_valid) begin
      check_eq("result", longint'($signed(result)), cos_ref(acc_tgt[0]), TOL);
      check_eq("squared", longint'(squared), sq_ref(acc_tgt[0]));
    end
  endtask

  task automatic step(input bit en, input bit st, input logic [21:0] tgt);
    clk_en = en;
    start  = st;
    target = tgt;
    @(posedge clk);
    if (en) begin
      ecount++;
      if (st) begin
        acc_edge.push_back(ecount);
        acc_tgt.push_back(tgt);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, rand_angle());
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_result"}, longint'(result), 0);
    check_eq({tag, "_squared"}, longint'(squared), 0);
    check_eq({tag, "_valid"}, longint'(valid), 0);
    check_eq({tag, "_cleared"}, longint'(pipeline_cleared), 1);
  endtask

  initial begin
    rst    = 1'b0;
    clk_en = 1'b0;
    start  = 1'b0;
    target = '0;
    #12;
    check_reset_state("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single sample at zero angle
    step(1'b1, 1'b1, 22'h000000);
    idle(20);

    // Known angles: 1.0 and -0.0625
    step(1'b1, 1'b1, 22'h100000);
    idle(3);
    step(1'b1, 1'b1, 22'h3F0000);
    idle(20);

    // +0.5 / -0.5 back to back
    step(1'b1, 1'b1, 22'h080000);
    step(1'b1, 1'b1, 22'h380000);
    idle(20);

    // Stall mid-flight; starts during the stall must be dropped
    step(1'b1, 1'b1, rand_angle());
    idle(5);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, rand_angle());
    idle(15);

    // Stall while a result is presented
    step(1'b1, 1'b1, 22'h0C0000);
    idle(17);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, rand_angle());
    idle(3);

    // Throughput: 32 consecutive random samples
    for (int k = 0; k < 32; k++) step(1'b1, 1'b1, rand_angle());
    idle(20);

    // Reset mid-stream with three samples in flight
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, rand_angle());
    idle(2);
    start = 1'b0;
    rst   = 1'b0;
    #1;
    check_reset_state("midrst");
    acc_edge.delete();
    acc_tgt.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
